game_mode_ctrl: RTL and testbench

- Parametrised round controller for the Mastermind codebreaker. It is the next generation of the two-mode practice/real selector.
- Selects practice or real mode and counts scored guesses against a configurable limit.
- Detects win or loss internally from the scorer's exact-match count and holds the outcome until restart.
- Sits between the switch/key debouncers, the peg scorer and the HEX/LED display drivers.

---
 rtl/mastermind_pkg.sv | 15 +
 rtl/game_mode_ctrl_guess_counter.sv | 29 ++
 rtl/game_mode_ctrl.sv | 112 +++++++++++
 tb/tb_game_mode_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared Mastermind types and default sizing for the round controller, scorer and display.
package mastermind_pkg;

  typedef enum logic [2:0] {
    PRACTICE = 3'd0,
    ARMED    = 3'd1,
    LOCKED   = 3'd2,
    WON      = 3'd3,
    LOST     = 3'd4
  } game_state_t;

  localparam int DEF_NUM_PEGS    = 4;
  localparam int DEF_MAX_GUESSES = 10;

endpackage

// File: rtl/game_mode_ctrl_guess_counter.sv
// Saturating guess counter with clear-over-increment priority; count/left/last follow the register.
// One-cycle update latency; no flow control, inc is sampled every edge.
module guess_counter #(
  parameter int MAX = 10,
  parameter int GW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [GW-1:0] count,
  output logic [GW-1:0] left,
  output logic          last
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != GW'(MAX))) begin
      count <= count + GW'(1);
    end
  end

  assign left = GW'(MAX) - count;
  assign last = (count == GW'(MAX - 1));

endmodule

// File: rtl/game_mode_ctrl.sv
// Mastermind round controller: practice/real mode, guess limit, win/loss latched until restart.
// Moore outputs change one clk edge after the inputs; no backpressure, guess_valid counts every high cycle.
module game_mode_ctrl
  import mastermind_pkg::*;
#(
  parameter  int NUM_PEGS    = DEF_NUM_PEGS,
  parameter  int MAX_GUESSES = DEF_MAX_GUESSES,
  localparam int PW          = $clog2(NUM_PEGS + 1),
  localparam int GW          = $clog2(MAX_GUESSES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          on,
  input  logic          off,
  input  logic          restart,
  input  logic          guess_valid,
  input  logic [PW-1:0] exact,
  output logic          real_game,
  output logic          locked,
  output logic [GW-1:0] guess_count,
  output logic [GW-1:0] guesses_left,
  output logic          win,
  output logic          lose,
  output logic          game_over
);

  game_state_t state, state_nxt;
  logic        win_real;
  logic        cnt_clr, cnt_inc, cnt_last;
  logic        hit;

  assign hit = guess_valid && (exact >= PW'(NUM_PEGS));

  guess_counter #(
    .MAX (MAX_GUESSES),
    .GW  (GW)
  ) u_guess_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (guess_count),
    .left  (guesses_left),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PRACTICE;
    end else begin
      state <= state_nxt;
    end
  end

  // Remembers whether the win was scored in real mode, captured on entry to WON.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_real <= 1'b0;
    end else if ((state != WON) && (state_nxt == WON)) begin
      win_real <= (state != PRACTICE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (restart) begin
      state_nxt = PRACTICE;
      cnt_clr   = 1'b1;
    end else begin
      case (state)
        PRACTICE: begin
          if (hit)     state_nxt = WON;
          else if (on) state_nxt = ARMED;
        end
        ARMED, LOCKED: begin
          if (guess_valid) begin
            cnt_inc = 1'b1;
            if (hit)           state_nxt = WON;
            else if (cnt_last) state_nxt = LOST;
            else               state_nxt = LOCKED;
          end else if ((state == ARMED) && off) begin
            state_nxt = PRACTICE;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    real_game = 1'b0;
    win       = 1'b0;
    lose      = 1'b0;
    case (state)
      ARMED, LOCKED: real_game = 1'b1;
      WON: begin
        real_game = win_real;
        win       = 1'b1;
      end
      LOST: begin
        real_game = 1'b1;
        lose      = 1'b1;
      end
      default: real_game = 1'b0;
    endcase
    locked    = real_game && (guess_count != '0);
    game_over = win | lose;
  end

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Bench for game_mode_ctrl: vector table plus hand-built loss/win/reset sequences through an expectation queue.
module tb_game_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       on = 1'b0, off = 1'b0, restart = 1'b0, guess_valid = 1'b0;
  logic [2:0] exact = '0;
  logic       real_game, locked, win, lose, game_over;
  logic [3:0] guess_count, guesses_left;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       restart;
    logic       on;
    logic       off;
    logic       gv;
    logic [2:0] exact;
  } in_t;

  typedef struct packed {
    logic       real_game;
    logic       locked;
    logic [3:0] cnt;
    logic [3:0] left;
    logic       win;
    logic       lose;
    logic       go;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  out_t exp_q[$];
  int   tag_q[$];

  game_mode_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .on           (on),
    .off          (off),
    .restart      (restart),
    .guess_valid  (guess_valid),
    .exact        (exact),
    .real_game    (real_game),
    .locked       (locked),
    .guess_count  (guess_count),
    .guesses_left (guesses_left),
    .win          (win),
    .lose         (lose),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  function automatic in_t mi(logic r, logic o_n, logic o_f, logic g, logic [2:0] e);
    in_t x;
    x.restart = r; x.on = o_n; x.off = o_f; x.gv = g; x.exact = e;
    return x;
  endfunction

  function automatic out_t mo(logic rg, logic lk, int c, logic w, logic l);
    out_t x;
    x.real_game = rg; x.locked = lk;
    x.cnt = 4'(c); x.left = 4'(10 - c);
    x.win = w; x.lose = l; x.go = w | l;
    return x;
  endfunction

  function automatic out_t actual();
    out_t x;
    x.real_game = real_game; x.locked = locked;
    x.cnt = guess_count; x.left = guesses_left;
    x.win = win; x.lose = lose; x.go = game_over;
    return x;
  endfunction

  task automatic check(input out_t e, input int tag);
    out_t a;
    a = actual();
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL step%0d: got rg=%b lk=%b cnt=%0d left=%0d win=%b lose=%b go=%b, want rg=%b lk=%b cnt=%0d left=%0d win=%b lose=%b go=%b",
               tag, a.real_game, a.locked, a.cnt, a.left, a.win, a.lose, a.go,
               e.real_game, e.locked, e.cnt, e.left, e.win, e.lose, e.go);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic apply(input in_t i, input out_t o, input int tag);
    @(negedge clk);
    restart = i.restart; on = i.on; off = i.off; guess_valid = i.gv; exact = i.exact;
    exp_q.push_back(o);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(exp_q.pop_front(), tag_q.pop_front());
  endtask

  in_t  idle;
  vec_t tbl[19];

  initial begin
    idle = mi(0, 0, 0, 0, 3'd0);

    tbl[0]  = '{mi(0,0,0,0,3'd0), mo(0,0,0,0,0)};
    tbl[1]  = '{mi(0,1,0,0,3'd0), mo(1,0,0,0,0)};
    tbl[2]  = '{mi(0,0,0,1,3'd2), mo(1,1,1,0,0)};
    tbl[3]  = '{mi(0,0,0,1,3'd2), mo(1,1,2,0,0)};
    tbl[4]  = '{mi(0,0,0,1,3'd2), mo(1,1,3,0,0)};
    tbl[5]  = '{mi(0,0,1,0,3'd0), mo(1,1,3,0,0)};
    tbl[6]  = '{mi(0,1,1,0,3'd0), mo(1,1,3,0,0)};
    tbl[7]  = '{mi(1,0,0,0,3'd0), mo(0,0,0,0,0)};
    tbl[8]  = '{mi(0,1,0,1,3'd4), mo(0,0,0,1,0)};
    tbl[9]  = '{mi(0,1,0,1,3'd2), mo(0,0,0,1,0)};
    tbl[10] = '{mi(1,0,0,0,3'd0), mo(0,0,0,0,0)};
    tbl[11] = '{mi(0,1,0,1,3'd3), mo(1,0,0,0,0)};
    tbl[12] = '{mi(0,1,1,0,3'd0), mo(0,0,0,0,0)};
    tbl[13] = '{mi(0,0,0,1,3'd7), mo(0,0,0,1,0)};
    tbl[14] = '{mi(1,0,0,1,3'd4), mo(0,0,0,0,0)};
    tbl[15] = '{mi(0,0,0,1,3'd2), mo(0,0,0,0,0)};
    tbl[16] = '{mi(0,1,0,0,3'd0), mo(1,0,0,0,0)};
    tbl[17] = '{mi(0,0,0,1,3'd4), mo(1,1,1,1,0)};
    tbl[18] = '{mi(1,0,0,0,3'd0), mo(0,0,0,0,0)};

    #2;
    check(mo(0,0,0,0,0), 900);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[k]) apply(tbl[k].i, tbl[k].o, k);

    // Ten misses in real mode end in LOST; an extra guess must not move the count.
    apply(mi(0,1,0,0,3'd0), mo(1,0,0,0,0), 100);
    for (int k = 1; k <= 10; k++)
      apply(mi(0,0,0,1,3'd1), mo(1,1,k,0,(k == 10)), 100 + k);
    apply(mi(0,0,0,1,3'd1), mo(1,1,10,0,1), 111);
    apply(mi(0,1,1,0,3'd0), mo(1,1,10,0,1), 112);
    apply(mi(1,0,0,1,3'd4), mo(0,0,0,0,0), 113);

    // Win on the final allowed guess takes precedence over the loss.
    apply(mi(0,1,0,0,3'd0), mo(1,0,0,0,0), 200);
    for (int k = 1; k <= 9; k++)
      apply(mi(0,0,0,1,3'd0), mo(1,1,k,0,0), 200 + k);
    apply(mi(0,0,0,1,3'd4), mo(1,1,10,1,0), 210);
    apply(mi(0,0,0,1,3'd1), mo(1,1,10,1,0), 211);
    apply(mi(1,0,0,0,3'd0), mo(0,0,0,0,0), 212);

    // Reset mid-LOCKED clears everything without waiting for a clock edge.
    apply(mi(0,1,0,0,3'd0), mo(1,0,0,0,0), 300);
    for (int k = 1; k <= 3; k++)
      apply(mi(0,0,0,1,3'd2), mo(1,1,k,0,0), 300 + k);
    @(negedge clk);
    restart = 0; on = 0; off = 0; guess_valid = 0; exact = '0;
    #2;
    reset = 1'b0;
    #1;
    check(mo(0,0,0,0,0), 304);
    @(negedge clk);
    reset = 1'b1;
    apply(idle, mo(0,0,0,0,0), 305);
    apply(mi(0,0,0,1,3'd4), mo(0,0,0,1,0), 306);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
